snd_axilite_bridge: RTL and testbench
=====================================

# snd_axilite_bridge

AXI4-Lite slave that drives the sound IP's simple register bus (WRADDR/BYTEEN/WREN/WDATA, RDADDR/RDEN/RDATA) into snd_regctl. It converts each AXI write into one single-cycle WREN strobe and each AXI read into one single-cycle RDEN strobe. It returns the registered RDATA from snd_regctl on the R channel. It sits between the PS interconnect and snd_regctl inside snd_ip.

## Interface
Parameters:
- C_S_AXI_ADDR_WIDTH, 16: AXI address width. Bits [15:0] are forwarded; upper bits are ignored.
- C_S_AXI_DATA_WIDTH, 32: fixed at 32. Any other value is unsupported.

Ports:
- ACLK  in  1  single clock for all logic.
- ARESETN  in  1  reset, synchronous, active-low.
- S_AXI_AWADDR  in  ADDR_W  write address. S_AXI_AWVALID in 1. S_AXI_AWREADY out 1.
- S_AXI_WDATA  in  32. S_AXI_WSTRB in 4. S_AXI_WVALID in 1. S_AXI_WREADY out 1.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY). S_AXI_BVALID out 1. S_AXI_BREADY in 1.
- S_AXI_ARADDR  in  ADDR_W. S_AXI_ARVALID in 1. S_AXI_ARREADY out 1.
- S_AXI_RDATA  out  32. S_AXI_RRESP out 2, always OKAY. S_AXI_RVALID out 1. S_AXI_RREADY in 1.
- WRADDR  out  16  register write address, registered.
- BYTEEN  out  4  copy of WSTRB, registered.
- WREN  out  1  one-cycle write strobe.
- WDATA  out  32  registered write data.
- RDADDR  out  16  registered read address.
- RDEN  out  1  one-cycle read strobe.
- RDATA  in  32  read data from snd_regctl. Valid from the cycle after RDEN and held until the next RDEN.

## Operation
- Write FSM states: W_IDLE, W_STROBE, W_RESP.
  - W_IDLE: AWREADY = !aw_held and WREADY = !w_held. Each channel is latched independently on its own handshake (aw_held/w_held, with addr/data/strobe captured). AW and W may arrive in either order or in the same cycle.
  - When both are held, or become held in this cycle, go to W_STROBE.
  - W_STROBE: WREN=1 for exactly one cycle, with WRADDR/BYTEEN/WDATA driven from the latches. Clear aw_held/w_held. Go to W_RESP.
  - W_RESP: BVALID=1 until BREADY is sampled high, then go to W_IDLE. AWREADY=WREADY=0 throughout.
- Read FSM states: R_IDLE, R_STROBE, R_RESP.
  - R_IDLE: ARREADY=1. On the ARVALID handshake, latch the address and go to R_STROBE.
  - R_STROBE: RDEN=1 for one cycle. Go to R_RESP.
  - R_RESP: RVALID=1 and S_AXI_RDATA = RDATA (pass-through; stable because no RDEN occurs until the handshake). Return to R_IDLE on RREADY.
- The read and write FSMs are fully independent. WREN and RDEN may be high in the same cycle; snd_regctl handles both.
- No address decode in the bridge. All 16 bits are forwarded and snd_regctl selects its space on [15:12]==3.
- BRESP and RRESP are always OKAY, including for addresses outside the regctl space.

## Timing
- Reset values (ARESETN low at a clock edge): both FSMs in idle, held flags 0, WREN=RDEN=0, BVALID=RVALID=0, WRADDR=RDADDR=0, WDATA=0, BYTEEN=0.
- AWREADY, WREADY and ARREADY are 0 in every cycle in which ARESETN is low. They are 1 in the first cycle after release.
- Write latency: AW and W handshaked in cycle t → WREN in t+1 → BVALID in t+2. If W arrives k cycles after AW, WREN follows one cycle after the later handshake.
- Read latency: AR handshaked in t → RDEN in t+1 → RVALID with valid RDATA in t+2.
- At most one write and one read are outstanding. A new AW/W/AR is not accepted until the previous B/R handshake completes.
- BVALID/RVALID held with BREADY/RREADY low: the response and data stay stable indefinitely.
- Reset mid-transaction: all state is discarded with no strobe emitted. A latched but unstrobed write is dropped.

## Structure
- Package snd_axilite_pkg holds:
  - the write-state enum {W_IDLE, W_STROBE, W_RESP};
  - the read-state enum {R_IDLE, R_STROBE, R_RESP};
  - the constant RESP_OKAY = 2'b00.
- No sub-module. The two FSMs are small, independent always blocks within one module.

## Test plan
- Write, AW and W in the same cycle: addr 0x3000, data 0x0123_4567, strb 0xF → WREN one cycle at t+1 with WRADDR=0x3000, BYTEEN=0xF, WDATA=0x0123_4567; BVALID at t+2 with BRESP=00.
- W three cycles before AW: data 0xA5, strb 0x1, addr 0x300C → WREADY drops after the W handshake; exactly one WREN, one cycle after AW; BYTEEN=0x1.
- Read: AR 0x3004 with the regctl model returning 0x0000_1000 → RDEN at t+1 with RDADDR=0x3004; RVALID at t+2 with RDATA=0x0000_1000; RREADY held low 5 cycles → data stable, no second RDEN.
- Concurrent write to 0x3008 and read of 0x3000 in the same cycle → WREN and RDEN both high at t+1; both responses complete independently.
- Back-pressure: BREADY low for 4 cycles → AWREADY/WREADY stay 0; a second AW is accepted only after the B handshake.
- Reset asserted in W_STROBE's preceding cycle, with AW held and W pending → no WREN; all outputs at reset values; the next write after release works normally.

Source files
------------

// File: rtl/snd_axilite_pkg.sv
// Shared types and constants for the sound IP AXI4-Lite register bridge.
package snd_axilite_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_STROBE,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_STROBE,
    R_RESP
  } rd_state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/snd_axilite_bridge.sv
// AXI4-Lite slave that turns each AXI write into one WREN strobe and each
// AXI read into one RDEN strobe on the snd_regctl register bus.
//
// Write FSM
//   state    | meaning
//   W_IDLE   | accepting AW and W independently, waiting for both
//   W_STROBE | WREN high for one cycle from the latched address/data/strobe
//   W_RESP   | BVALID high until BREADY
// Read FSM
//   state    | meaning
//   R_IDLE   | accepting AR
//   R_STROBE | RDEN high for one cycle
//   R_RESP   | RVALID high with RDATA passed through until RREADY
module snd_axilite_bridge
  import snd_axilite_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 16,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [15:0]                     WRADDR,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] BYTEEN,
  output logic                            WREN,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
  output logic [15:0]                     RDADDR,
  output logic                            RDEN,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA
);

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  logic                            aw_held, w_held;
  logic                            aw_hs, w_hs, ar_hs;
  logic [15:0]                     wr_addr_q, rd_addr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data_q;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb_q;

  assign WRADDR      = wr_addr_q;
  assign BYTEEN      = wr_strb_q;
  assign WDATA       = wr_data_q;
  assign RDADDR      = rd_addr_q;
  assign S_AXI_BRESP = RESP_OKAY;
  assign S_AXI_RRESP = RESP_OKAY;
  assign S_AXI_RDATA = RDATA;

  // Write FSM next state and outputs; readies and strobe are gated by reset
  // so nothing is accepted or emitted while ARESETN is low.
  always_comb begin
    wr_state_nxt  = wr_state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    WREN          = 1'b0;
    aw_hs         = 1'b0;
    w_hs          = 1'b0;
    case (wr_state)
      W_IDLE: begin
        S_AXI_AWREADY = ARESETN && !aw_held;
        S_AXI_WREADY  = ARESETN && !w_held;
        aw_hs         = S_AXI_AWVALID && S_AXI_AWREADY;
        w_hs          = S_AXI_WVALID && S_AXI_WREADY;
        if ((aw_held || aw_hs) && (w_held || w_hs)) begin
          wr_state_nxt = W_STROBE;
        end
      end
      W_STROBE: begin
        WREN         = ARESETN;
        wr_state_nxt = W_RESP;
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) begin
          wr_state_nxt = W_IDLE;
        end
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  // Write state register plus independent AW and W capture latches.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_state  <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
    end else begin
      wr_state <= wr_state_nxt;
      if (wr_state == W_STROBE) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          wr_addr_q <= S_AXI_AWADDR[15:0];
        end
        if (w_hs) begin
          w_held    <= 1'b1;
          wr_data_q <= S_AXI_WDATA;
          wr_strb_q <= S_AXI_WSTRB;
        end
      end
    end
  end

  // Read FSM next state and outputs.
  always_comb begin
    rd_state_nxt  = rd_state;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    RDEN          = 1'b0;
    ar_hs         = 1'b0;
    case (rd_state)
      R_IDLE: begin
        S_AXI_ARREADY = ARESETN;
        ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;
        if (ar_hs) begin
          rd_state_nxt = R_STROBE;
        end
      end
      R_STROBE: begin
        RDEN         = ARESETN;
        rd_state_nxt = R_RESP;
      end
      R_RESP: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) begin
          rd_state_nxt = R_IDLE;
        end
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  // Read state register and address latch.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rd_state  <= R_IDLE;
      rd_addr_q <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      if (ar_hs) begin
        rd_addr_q <= S_AXI_ARADDR[15:0];
      end
    end
  end

endmodule

// File: tb/tb_snd_axilite_bridge.sv
// Self-checking bench for snd_axilite_bridge: directed cases plus randomized
// transactions, with a scoreboard monitor checking the register-bus strobes
// and AXI responses against expectations queued by the stimulus.
module tb_snd_axilite_bridge;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [15:0] S_AXI_AWADDR = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [15:0] S_AXI_ARADDR = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic [15:0] WRADDR;
  logic [3:0]  BYTEEN;
  logic        WREN;
  logic [31:0] WDATA;
  logic [15:0] RDADDR;
  logic        RDEN;
  logic [31:0] RDATA = '0;

  snd_axilite_bridge #(
    .C_S_AXI_ADDR_WIDTH(16),
    .C_S_AXI_DATA_WIDTH(32)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY),
    .WRADDR(WRADDR), .BYTEEN(BYTEEN), .WREN(WREN), .WDATA(WDATA),
    .RDADDR(RDADDR), .RDEN(RDEN), .RDATA(RDATA)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int          c;
  } wr_exp_t;

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
    int          c;
  } rd_exp_t;

  wr_exp_t exp_wr[$];
  rd_exp_t exp_rd[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int b_count = 0, r_count = 0;
  int wr_issued = 0, rd_issued = 0;
  int b_wait = 0, r_wait = 0;
  int aw_t, w_t;
  logic [15:0] cur_a;
  logic [31:0] cur_d;
  logic [3:0]  cur_s;

  // Register file stand-in: per-address read value.
  function automatic logic [31:0] rd_model(input logic [15:0] a);
    if (a == 16'h3004) return 32'h0000_1000;
    return {~a, a} ^ 32'h5a5a_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge ACLK) cyc <= cyc + 1;

  // Register-bus read data: registered, updated on RDEN.
  always @(posedge ACLK) if (RDEN) RDATA <= rd_model(RDADDR);

  // Response back-pressure drivers.
  initial forever begin
    @(posedge ACLK); #1;
    if (S_AXI_BVALID && b_wait > 0) begin
      S_AXI_BREADY = 1'b0;
      b_wait--;
    end else S_AXI_BREADY = S_AXI_BVALID;
  end

  initial forever begin
    @(posedge ACLK); #1;
    if (S_AXI_RVALID && r_wait > 0) begin
      S_AXI_RREADY = 1'b0;
      r_wait--;
    end else S_AXI_RREADY = S_AXI_RVALID;
  end

  // Scoreboard monitor.
  initial begin
    int last_wren, last_rden;
    logic bv_prev, rv_prev;
    logic [31:0] rexp;
    wr_exp_t we;
    rd_exp_t re;
    last_wren = -10; last_rden = -10; bv_prev = 0; rv_prev = 0; rexp = '0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        chk("rst_readys", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd0);
        chk("rst_strobes", {30'd0, WREN, RDEN}, 32'd0);
        bv_prev = 0; rv_prev = 0;
      end else begin
        if (WREN) begin
          if (exp_wr.size() == 0) chk("spurious_wren", 32'd1, 32'd0);
          else begin
            we = exp_wr.pop_front();
            chk("wraddr", {16'd0, WRADDR}, {16'd0, we.a});
            chk("wdata", WDATA, we.d);
            chk("byteen", {28'd0, BYTEEN}, {28'd0, we.s});
            chk("wren_cycle", cyc, we.c);
          end
          last_wren = cyc;
        end
        if (S_AXI_BVALID) begin
          if (!bv_prev) chk("bvalid_cycle", cyc, last_wren + 1);
          chk("bresp", {30'd0, S_AXI_BRESP}, 32'd0);
          chk("ready_during_b", {30'd0, S_AXI_AWREADY, S_AXI_WREADY}, 32'd0);
          if (S_AXI_BREADY) b_count++;
        end
        bv_prev = S_AXI_BVALID;
        if (RDEN) begin
          if (exp_rd.size() == 0) chk("spurious_rden", 32'd1, 32'd0);
          else begin
            re = exp_rd.pop_front();
            chk("rdaddr", {16'd0, RDADDR}, {16'd0, re.a});
            chk("rden_cycle", cyc, re.c);
            rexp = re.d;
          end
          last_rden = cyc;
        end
        if (S_AXI_RVALID) begin
          if (!rv_prev) chk("rvalid_cycle", cyc, last_rden + 1);
          chk("rdata", S_AXI_RDATA, rexp);
          chk("rresp", {30'd0, S_AXI_RRESP}, 32'd0);
          chk("arready_during_r", {31'd0, S_AXI_ARREADY}, 32'd0);
          if (S_AXI_RREADY) r_count++;
        end
        rv_prev = S_AXI_RVALID;
      end
    end
  end

  task automatic push_wr();
    wr_exp_t e;
    e.a = cur_a; e.d = cur_d; e.s = cur_s; e.c = cyc + 1;
    exp_wr.push_back(e);
  endtask

  task automatic drive_aw(input int dly, input int idx);
    int n;
    repeat (dly) @(posedge ACLK);
    @(posedge ACLK); #1;
    S_AXI_AWADDR = cur_a; S_AXI_AWVALID = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!S_AXI_AWREADY && n < 200);
    if (!S_AXI_AWREADY) chk("aw_timeout", 32'd0, 32'd1);
    else begin
      chk("aw_after_prev_b", b_count, idx - 1);
      aw_t = cyc;
      if (w_t >= 0) push_wr();
    end
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    @(negedge ACLK);
    chk("awready_drop", {31'd0, S_AXI_AWREADY}, 32'd0);
  endtask

  task automatic drive_w(input int dly);
    int n;
    repeat (dly) @(posedge ACLK);
    @(posedge ACLK); #1;
    S_AXI_WDATA = cur_d; S_AXI_WSTRB = cur_s; S_AXI_WVALID = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!S_AXI_WREADY && n < 200);
    if (!S_AXI_WREADY) chk("w_timeout", 32'd0, 32'd1);
    else begin
      w_t = cyc;
      if (aw_t >= 0) push_wr();
    end
    @(posedge ACLK); #1;
    S_AXI_WVALID = 1'b0;
    @(negedge ACLK);
    chk("wready_drop", {31'd0, S_AXI_WREADY}, 32'd0);
  endtask

  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input bit wait_b);
    int my, n;
    wr_issued++;
    my = wr_issued;
    cur_a = a; cur_d = d; cur_s = s;
    aw_t = -1; w_t = -1;
    fork
      drive_aw(aw_dly, my);
      drive_w(w_dly);
    join
    if (wait_b) begin
      n = 0;
      while (b_count < my && n < 300) begin @(negedge ACLK); n++; end
      if (b_count < my) chk("b_timeout", b_count, my);
    end
  endtask

  task automatic axi_read(input logic [15:0] a, input int dly);
    int my, n;
    rd_exp_t e;
    rd_issued++;
    my = rd_issued;
    repeat (dly) @(posedge ACLK);
    @(posedge ACLK); #1;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!S_AXI_ARREADY && n < 200);
    if (!S_AXI_ARREADY) chk("ar_timeout", 32'd0, 32'd1);
    else begin
      chk("ar_after_prev_r", r_count, my - 1);
      e.a = a; e.d = rd_model(a); e.c = cyc + 1;
      exp_rd.push_back(e);
    end
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (r_count < my && n < 300) begin @(negedge ACLK); n++; end
    if (r_count < my) chk("r_timeout", r_count, my);
  endtask

  task automatic check_reset_values();
    chk("rst_wraddr", {16'd0, WRADDR}, 32'd0);
    chk("rst_wdata", WDATA, 32'd0);
    chk("rst_byteen", {28'd0, BYTEEN}, 32'd0);
    chk("rst_rdaddr", {16'd0, RDADDR}, 32'd0);
    chk("rst_valids", {30'd0, S_AXI_BVALID, S_AXI_RVALID}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check_reset_values();
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("ready_after_release", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h7);

    // AW and W together.
    axi_write(16'h3000, 32'h0123_4567, 4'hF, 0, 0, 1);
    // W three cycles ahead of AW.
    axi_write(16'h300C, 32'h0000_00A5, 4'h1, 3, 0, 1);
    // Read with RREADY held off for 5 cycles.
    r_wait = 5;
    axi_read(16'h3004, 0);
    // Concurrent write and read issued in the same cycle.
    fork
      axi_write(16'h3008, 32'hDEAD_BEEF, 4'h6, 0, 0, 1);
      axi_read(16'h3000, 0);
    join
    // B back-pressure with a second write queued behind it.
    b_wait = 4;
    axi_write(16'h3010, 32'h1111_2222, 4'hC, 0, 1, 0);
    axi_write(16'h3014, 32'h3333_4444, 4'h3, 0, 0, 1);

    // Reset while AW is held and W is pending: the write must vanish.
    @(posedge ACLK); #1;
    S_AXI_AWADDR = 16'h3018; S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    chk("rst_case_aw_accept", {31'd0, S_AXI_AWREADY}, 32'd1);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = 32'hCAFE_F00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    ARESETN = 1'b0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    check_reset_values();
    @(posedge ACLK); #1;
    ARESETN = 1'b1; S_AXI_WVALID = 1'b0;
    @(negedge ACLK);
    chk("ready_after_rerelease", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h7);
    axi_write(16'h301C, 32'h5566_7788, 4'hA, 0, 0, 1);

    // Randomized mix of writes, reads and concurrent pairs.
    for (int i = 0; i < 40; i++) begin
      int kind;
      logic [15:0] wa, ra;
      logic [31:0] wd;
      logic [3:0] ws;
      int ad, wdly;
      kind = $urandom_range(0, 2);
      wa = 16'($urandom); ra = 16'($urandom);
      wd = $urandom; ws = 4'($urandom);
      ad = $urandom_range(0, 3); wdly = $urandom_range(0, 3);
      b_wait = $urandom_range(0, 3);
      r_wait = $urandom_range(0, 3);
      case (kind)
        0: axi_write(wa, wd, ws, ad, wdly, 1);
        1: axi_read(ra, ad);
        default: fork
          axi_write(wa, wd, ws, ad, wdly, 1);
          axi_read(ra, wdly);
        join
      endcase
    end

    repeat (5) @(posedge ACLK);
    @(negedge ACLK);
    chk("wr_queue_drained", exp_wr.size(), 32'd0);
    chk("rd_queue_drained", exp_rd.size(), 32'd0);
    chk("b_total", b_count, wr_issued);
    chk("r_total", r_count, rd_issued);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
